// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
// State encodings match the documented IDLE/WAIT/ACCESS/ACK values.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } arb_state_t;

    localparam int DM_ADDR_W   = 4;
    localparam int DM_DATA_W   = 4;
    localparam int DM_MAX_WAIT = 8;

endpackage

// File: rtl/dm_arbiter_if.sv
// Host-side port of the data-memory arbiter (loader/debug access).
// The master modport is the host; the slave modport is the arbiter.
interface dm_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    logic              busy;

    modport master (
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata, busy
    );

    modport slave (
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata, busy
    );
endinterface

// File: rtl/sat_counter8.sv
// 8-bit event counter that sticks at 255 until reset.
module sat_counter8 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    output logic [7:0] count
);
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end
endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the single-port data memory between the core and a host port.
// Optional event counters are enabled with the DM_ARB_STATS_EN macro.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W   = DM_ADDR_W,
    parameter int DATA_W   = DM_DATA_W,
    parameter int MAX_WAIT = DM_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wren,
    output logic              cpu_hold,
    dm_arbiter_if.slave       host,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
`ifdef DM_ARB_STATS_EN
    ,
    output logic [7:0]        stat_grants,
    output logic [7:0]        stat_forced
`endif
);
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_r;
    logic              busy_r;
    logic [DATA_W-1:0] rdata_r;

    assign host.host_ack   = ack_r;
    assign host.busy       = busy_r;
    assign host.host_rdata = rdata_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            cpu_hold <= 1'b0;
            ack_r    <= 1'b0;
            busy_r   <= 1'b0;
            rdata_r  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            ack_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (host.host_req) begin
                        we_q     <= host.host_we;
                        addr_q   <= host.host_addr;
                        wdata_q  <= host.host_wdata;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                // Core writes keep flowing until a gap appears or the wait limit is hit.
                ST_WAIT: begin
                    if (!cpu_wren || wait_cnt == WAIT_LAST) begin
                        state    <= ST_ACCESS;
                        cpu_hold <= 1'b1;
                        busy_r   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                // Memory read happened on the falling edge inside this cycle.
                ST_ACCESS: begin
                    state <= ST_ACK;
                    ack_r <= 1'b1;
                    if (!we_q) begin
                        rdata_r <= mem_q;
                    end
                end
                ST_ACK: begin
                    state    <= ST_IDLE;
                    cpu_hold <= 1'b0;
                    busy_r   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // During ACK the core address is presented with writes blocked so q is valid on release.
    always_comb begin
        mem_addr = cpu_addr;
        mem_data = cpu_wdata;
        mem_wren = cpu_wren;
        case (state)
            ST_ACCESS: begin
                mem_addr = addr_q;
                mem_data = wdata_q;
                mem_wren = we_q;
            end
            ST_ACK:  mem_wren = 1'b0;
            default: ;
        endcase
    end

`ifdef DM_ARB_STATS_EN
    logic grant_evt;
    logic forced_evt;

    assign grant_evt  = (state == ST_ACK);
    assign forced_evt = (state == ST_WAIT) && cpu_wren && (wait_cnt == WAIT_LAST);

    sat_counter8 u_grants (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (grant_evt),
        .count   (stat_grants)
    );

    sat_counter8 u_forced (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (forced_evt),
        .count   (stat_forced)
    );
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// Randomized bench for dm_arbiter with a transaction-level reference model
// and a falling-edge data memory; stat checks enabled by DM_ARB_STATS_EN.
module tb_dm_arbiter;
    localparam int MW = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cpu_addr;
    logic [3:0] cpu_wdata;
    logic       cpu_wren;
    logic       cpu_hold;
    logic [3:0] mem_addr;
    logic [3:0] mem_data;
    logic       mem_wren;
    logic [3:0] mem_q = 4'h0;
`ifdef DM_ARB_STATS_EN
    logic [7:0] stat_grants;
    logic [7:0] stat_forced;
    int         grants_ref = 0;
    int         forced_ref = 0;
`endif

    dm_arbiter_if #(.ADDR_W(4), .DATA_W(4)) hif ();

    dm_arbiter #(.ADDR_W(4), .DATA_W(4), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wren  (cpu_wren),
        .cpu_hold  (cpu_hold),
        .host      (hif),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q)
`ifdef DM_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_forced (stat_forced)
`endif
    );

    always #5 clk = ~clk;

    // Data memory: writes and registered read on the falling edge.
    logic [3:0] mem [16] = '{default: 4'h0};
    always @(negedge clk) begin
        if (mem_wren) mem[mem_addr] <= mem_data;
        mem_q <= mem[mem_addr];
    end

    logic [3:0] ref_mem [16] = '{default: 4'h0};
    logic [3:0] ref_rdata = 4'h0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat255(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    task automatic note_txn(input bit forced);
`ifdef DM_ARB_STATS_EN
        grants_ref = sat255(grants_ref);
        if (forced) forced_ref = sat255(forced_ref);
`else
        if (forced) begin end
`endif
    endtask

    task automatic check_stats();
`ifdef DM_ARB_STATS_EN
        chk("stat_grants", 32'(stat_grants), 32'(grants_ref));
        chk("stat_forced", 32'(stat_forced), 32'(forced_ref));
`endif
    endtask

    task automatic clear_stats();
`ifdef DM_ARB_STATS_EN
        grants_ref = 0;
        forced_ref = 0;
`endif
    endtask

    // One core cycle in a pass-through state; write lands in the model when enabled.
    task automatic core_cycle(input bit wr, input logic [3:0] a, input logic [3:0] d);
        cpu_wren  = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        if (wr) ref_mem[a] = d;
    endtask

    // One host transaction; n = consecutive core-write cycles offered after acceptance.
    task automatic txn(input bit we, input logic [3:0] addr, input logic [3:0] wdata,
                       input int n, input bit keep_req);
        int  wait_len;
        bit  forced;
        hif.host_req   = 1'b1;
        hif.host_we    = we;
        hif.host_addr  = addr;
        hif.host_wdata = wdata;
        core_cycle(1'($urandom), 4'($urandom), 4'($urandom));
        step();
        chk("wait_hold", 32'(cpu_hold), 32'd0);
        hif.host_req   = keep_req;
        hif.host_we    = 1'($urandom);
        hif.host_addr  = 4'($urandom);
        hif.host_wdata = 4'($urandom);
        forced   = (n >= MW);
        wait_len = forced ? MW : n + 1;
        for (int k = 0; k < wait_len; k++) begin
            core_cycle(k < n, 4'($urandom), 4'($urandom));
            step();
            if (k < wait_len - 1) begin
                chk("wait_hold", 32'(cpu_hold), 32'd0);
                chk("wait_ack", 32'(hif.host_ack), 32'd0);
            end else begin
                chk("access_hold", 32'(cpu_hold), 32'd1);
                chk("access_busy", 32'(hif.busy), 32'd1);
                chk("access_ack", 32'(hif.host_ack), 32'd0);
            end
        end
        // Frozen core keeps asserting a write that must not reach memory.
        cpu_wren  = 1'b1;
        cpu_addr  = 4'($urandom);
        cpu_wdata = 4'($urandom);
        if (we) ref_mem[addr] = wdata;
        else    ref_rdata     = ref_mem[addr];
        step();
        chk("ack_pulse", 32'(hif.host_ack), 32'd1);
        chk("ack_hold", 32'(cpu_hold), 32'd1);
        chk("ack_busy", 32'(hif.busy), 32'd1);
        chk("ack_rdata", 32'(hif.host_rdata), 32'(ref_rdata));
        cpu_addr  = 4'($urandom);
        cpu_wdata = 4'($urandom);
        step();
        cpu_wren = 1'b0;
        chk("idle_ack", 32'(hif.host_ack), 32'd0);
        chk("idle_hold", 32'(cpu_hold), 32'd0);
        chk("idle_busy", 32'(hif.busy), 32'd0);
        chk("mem_word", 32'(mem[addr]), 32'(ref_mem[addr]));
        note_txn(forced);
    endtask

    task automatic core_wr(input logic [3:0] a, input logic [3:0] d);
        core_cycle(1'b1, a, d);
        step();
        cpu_wren = 1'b0;
    endtask

    initial begin
        bit keep;
        reset_n        = 1'b0;
        cpu_addr       = 4'h0;
        cpu_wdata      = 4'h0;
        cpu_wren       = 1'b0;
        hif.host_req   = 1'b0;
        hif.host_we    = 1'b0;
        hif.host_addr  = 4'h0;
        hif.host_wdata = 4'h0;
        repeat (3) step();
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_ack", 32'(hif.host_ack), 32'd0);
        chk("rst_busy", 32'(hif.busy), 32'd0);
        chk("rst_rdata", 32'(hif.host_rdata), 32'd0);
        check_stats();
        reset_n = 1'b1;
        step();

        // Plain read of a word the core just wrote.
        core_wr(4'd5, 4'hA);
        txn(1'b0, 4'd5, 4'h0, 0, 1'b0);
        chk("t1_rdata", 32'(hif.host_rdata), 32'hA);

        // Host write then read back; then the core reads the same word.
        txn(1'b1, 4'd3, 4'h7, 0, 1'b0);
        chk("t2_rdata_kept", 32'(hif.host_rdata), 32'hA);
        txn(1'b0, 4'd3, 4'h0, 0, 1'b0);
        chk("t2_rdata", 32'(hif.host_rdata), 32'h7);
        cpu_addr = 4'd3;
        @(negedge clk);
        #1;
        chk("t2_core_view", 32'(mem_q), 32'h7);
        step();

        // Continuous core writes force the hold after the wait limit.
        txn(1'b0, 4'd12, 4'h0, MW + 6, 1'b0);
        check_stats();

        // Request held high across three back-to-back transactions.
        txn(1'b0, 4'd1, 4'h0, 1, 1'b1);
        txn(1'b1, 4'd2, 4'h4, 2, 1'b1);
        txn(1'b0, 4'd2, 4'h0, 0, 1'b0);
        chk("t4_rdata", 32'(hif.host_rdata), 32'h4);
        check_stats();

        // Reset during ACCESS of a host write: write lost, outputs drop at once.
        core_wr(4'd9, 4'h2);
        hif.host_req   = 1'b1;
        hif.host_we    = 1'b1;
        hif.host_addr  = 4'd9;
        hif.host_wdata = 4'hD;
        step();
        hif.host_req = 1'b0;
        step();
        chk("t5_access_hold", 32'(cpu_hold), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_hold", 32'(cpu_hold), 32'd0);
        chk("t5_rst_busy", 32'(hif.busy), 32'd0);
        chk("t5_rst_ack", 32'(hif.host_ack), 32'd0);
        ref_rdata = 4'h0;
        clear_stats();
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("t5_mem9", 32'(mem[9]), 32'h2);
        txn(1'b0, 4'd9, 4'h0, 0, 1'b0);
        chk("t5_after_rdata", 32'(hif.host_rdata), 32'h2);

        // Randomized traffic; long enough to saturate the grant counter.
        keep = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!keep) begin
                hif.host_req = 1'b0;
                for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
                    core_cycle(1'($urandom), 4'($urandom), 4'($urandom));
                    step();
                end
            end
            keep = (i < 299) && ($urandom_range(3, 0) == 0);
            txn(1'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(MW + 3, 0)), keep);
        end
        hif.host_req = 1'b0;
        cpu_wren     = 1'b0;
        step();
        for (int a = 0; a < 16; a++) begin
            chk($sformatf("final_mem%0d", a), 32'(mem[a]), 32'(ref_mem[a]));
        end
        check_stats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
